// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the core_sequencer program feeder.
// Optional single-step issue is enabled by defining CORE_SEQUENCER_SINGLE_STEP_EN.
package core_sequencer_pkg;

    localparam int INSTR_W = 17;
    localparam int CTRL_W  = 3;
    localparam int PROG_W  = 20;

    localparam logic [INSTR_W-1:0] NOP = 17'h0;

    localparam logic [CTRL_W-1:0] CTRL_NORMAL     = 3'd0;
    localparam logic [CTRL_W-1:0] CTRL_LOOP_START = 3'd1;
    localparam logic [CTRL_W-1:0] CTRL_LOOP_END   = 3'd2;
    localparam logic [CTRL_W-1:0] CTRL_WAIT_INPUT = 3'd3;
    localparam logic [CTRL_W-1:0] CTRL_HALT       = 3'd4;

    // Field layout of the instruction word as decoded by core_sim.
    localparam int INSTR_ADDR_MSB      = 16;
    localparam int INSTR_ADDR_LSB      = 10;
    localparam int INSTR_WRITE_BIT     = 9;
    localparam int INSTR_ALU_MSB       = 8;
    localparam int INSTR_ALU_LSB       = 5;
    localparam int INSTR_INPUT_SEL_MSB = 4;
    localparam int INSTR_INPUT_SEL_LSB = 3;
    localparam int INSTR_OUT_SEL_BIT   = 2;
    localparam int INSTR_OUT_EN_BIT    = 1;
    localparam int INSTR_SAVE_SEL_BIT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RUN,
        ST_WAIT,
        ST_BUBBLE
    } state_t;

    function automatic logic [CTRL_W-1:0] prog_ctrl(input logic [PROG_W-1:0] word);
        return word[PROG_W-1:INSTR_W];
    endfunction

    function automatic logic [INSTR_W-1:0] prog_payload(input logic [PROG_W-1:0] word);
        return word[INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/core_sequencer_program_ram.sv
// Program store for core_sequencer: one write port, one registered read port.
// A deasserted read enable holds the last read word.
module sequencer_program_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/core_sequencer.sv
// Fetches microprogram words and broadcasts instruction/operand to the core array.
// Define CORE_SEQUENCER_SINGLE_STEP_EN to add step_i gating of issue in RUN.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LOOP_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
    input  logic               step_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    input  logic [LOOP_W-1:0]  loop_count_i,
    input  logic               prog_write_i,
    input  logic [ADDR_W-1:0]  prog_address_i,
    input  logic [PROG_W-1:0]  prog_data_i,
    input  logic [63:0]        input_data_i,
    input  logic               input_valid_i,
    output logic               input_ready_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [63:0]        input_o
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic [ADDR_W-1:0]   loop_start_q, loop_start_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [63:0]         input_q, input_d;
    logic                done_q, done_d;

    logic                ram_rd_en;
    logic [PROG_W-1:0]   ram_rd_data;
    logic [CTRL_W-1:0]   word_ctrl;
    logic [INSTR_W-1:0]  word_payload;
    logic                issue;

    sequencer_program_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PROG_W)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (prog_write_i && (state_q == ST_IDLE)),
        .wr_addr_i (prog_address_i),
        .wr_data_i (prog_data_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (pc_q),
        .rd_data_o (ram_rd_data)
    );

    assign word_ctrl    = prog_ctrl(ram_rd_data);
    assign word_payload = prog_payload(ram_rd_data);

`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
    assign issue = step_i;
`else
    assign issue = 1'b1;
`endif

    // The word in ram_rd_data lives at pc_q-1; withholding the read enable
    // keeps it (and the prefetch) stable while waiting or not stepping.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        loop_cnt_d   = loop_cnt_q;
        loop_start_d = loop_start_q;
        instr_d      = NOP;
        input_d      = input_q;
        done_d       = 1'b0;
        ram_rd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH, ST_BUBBLE: begin
                ram_rd_en = 1'b1;
                pc_d      = pc_q + ADDR_W'(1);
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (issue) begin
                    case (word_ctrl)
                        CTRL_LOOP_START: begin
                            instr_d      = word_payload;
                            loop_start_d = pc_q;
                            loop_cnt_d   = (loop_count_i == '0) ? LOOP_W'(1) : loop_count_i;
                            ram_rd_en    = 1'b1;
                            pc_d         = pc_q + ADDR_W'(1);
                        end
                        CTRL_LOOP_END: begin
                            instr_d = word_payload;
                            if (loop_cnt_q > LOOP_W'(1)) begin
                                loop_cnt_d = loop_cnt_q - LOOP_W'(1);
                                pc_d       = loop_start_q;
                                state_d    = ST_BUBBLE;
                            end else begin
                                loop_cnt_d = '0;
                                ram_rd_en  = 1'b1;
                                pc_d       = pc_q + ADDR_W'(1);
                            end
                        end
                        CTRL_WAIT_INPUT: begin
                            state_d = ST_WAIT;
                        end
                        CTRL_HALT: begin
                            done_d       = 1'b1;
                            pc_d         = '0;
                            loop_cnt_d   = '0;
                            loop_start_d = '0;
                            state_d      = ST_IDLE;
                        end
                        default: begin
                            instr_d   = word_payload;
                            ram_rd_en = 1'b1;
                            pc_d      = pc_q + ADDR_W'(1);
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (input_valid_i) begin
                    input_d   = input_data_i;
                    instr_d   = word_payload;
                    ram_rd_en = 1'b1;
                    pc_d      = pc_q + ADDR_W'(1);
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            loop_cnt_q   <= '0;
            loop_start_q <= '0;
            instr_q      <= NOP;
            input_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            loop_cnt_q   <= loop_cnt_d;
            loop_start_q <= loop_start_d;
            instr_q      <= instr_d;
            input_q      <= input_d;
            done_q       <= done_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign input_ready_o = (state_q == ST_WAIT);
    assign done_o        = done_q;
    assign instruction_o = instr_q;
    assign input_o       = input_q;

endmodule
